// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with a 2-entry in-order result FIFO and one-cycle latency.
// Optional macro LOGIC_NOR_EN: op 3 computes ~(A | B); otherwise op 3 aliases A & B.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] mem_data [0:1];
    logic [1:0]       mem_zero;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [WIDTH-1:0] op_result;
    logic             push;
    logic             pop;

    always_comb begin
        op_result = '0;
        case (req_op)
            2'd0:    op_result = req_a & req_b;
            2'd1:    op_result = req_a | req_b;
            2'd2:    op_result = req_a ^ req_b;
`ifdef LOGIC_NOR_EN
            default: op_result = ~(req_a | req_b);
`else
            default: op_result = req_a & req_b;
`endif
        endcase
    end

    assign req_ready  = (count != 2'd2);
    assign rsp_valid  = (count != 2'd0);
    assign level      = count;
    assign push       = req_valid && req_ready;
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_result = mem_data[rd_ptr];
    assign rsp_zero   = mem_zero[rd_ptr];

    // Zero flag is stored alongside each entry so the output never sees the adder-free compare path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_zero    <= '1;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= op_result;
                mem_zero[wr_ptr] <= (op_result == '0);
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: queue-based reference model plus directed scenarios.
module tb_logic_unit_pipe;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;
    logic [1:0]   level;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] q [$];

    logic [W-1:0] exp_op3;
    logic         exp_op3_zero;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .level      (level)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_op(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        case (op)
            2'd0: return a & b;
            2'd1: return a | b;
            2'd2: return a ^ b;
`ifdef LOGIC_NOR_EN
            default: return ~(a | b);
`else
            default: return a & b;
`endif
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of expected results, occupancy is the queue size.
    always @(posedge clk or posedge reset) begin
        logic do_pop;
        logic do_push;
        if (reset) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && rsp_ready;
            do_push = req_valid && (q.size() != 2);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(model_op(req_op, req_a, req_b));
        end
    end

    always @(negedge clk) begin
        check("model_level", {62'd0, level}, q.size());
        check("model_req_ready", {63'd0, req_ready}, {63'd0, q.size() != 2});
        check("model_rsp_valid", {63'd0, rsp_valid}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            check("model_rsp_result", {32'd0, rsp_result}, {32'd0, q[0]});
            check("model_rsp_zero", {63'd0, rsp_zero}, {63'd0, q[0] == '0});
        end
    end

    task automatic step(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic rr);
        req_valid = v;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef LOGIC_NOR_EN
        exp_op3      = 32'hFF00_0000;
        exp_op3_zero = 1'b0;
`else
        exp_op3      = 32'h0000_0000;
        exp_op3_zero = 1'b1;
`endif
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1;
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_level", {62'd0, level}, 64'd0);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_rsp_result", {32'd0, rsp_result}, 64'd0);
        check("rst_rsp_zero", {63'd0, rsp_zero}, 64'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // AND with one-cycle latency
        step(1'b1, 2'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        check("and_valid", {63'd0, rsp_valid}, 64'd1);
        check("and_result", {32'd0, rsp_result}, 64'hF000_F000);
        check("and_zero", {63'd0, rsp_zero}, 64'd0);
        step(1'b0, 2'd0, '0, '0, 1'b1);
        check("and_drained", {62'd0, level}, 64'd0);

        // Fill to full, third request ignored, then drain in order
        step(1'b1, 2'd1, 32'h1, 32'h2, 1'b0);
        step(1'b1, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("full_level", {62'd0, level}, 64'd2);
        check("full_req_ready", {63'd0, req_ready}, 64'd0);
        check("full_head", {32'd0, rsp_result}, 64'h3);
        step(1'b1, 2'd0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        check("ignored_level", {62'd0, level}, 64'd2);
        check("ignored_head", {32'd0, rsp_result}, 64'h3);
        step(1'b0, 2'd0, '0, '0, 1'b1);
        check("drain1_level", {62'd0, level}, 64'd1);
        check("drain1_result", {32'd0, rsp_result}, 64'h0);
        check("drain1_zero", {63'd0, rsp_zero}, 64'd1);
        step(1'b0, 2'd0, '0, '0, 1'b1);
        check("drain2_level", {62'd0, level}, 64'd0);

        // Pop on empty is ignored
        step(1'b0, 2'd0, '0, '0, 1'b1);
        check("empty_pop_level", {62'd0, level}, 64'd0);
        check("empty_pop_ready", {63'd0, req_ready}, 64'd1);

        // Simultaneous push and pop at level 1
        step(1'b1, 2'd2, 32'h0F, 32'hFF, 1'b0);
        check("l1_head", {32'd0, rsp_result}, 64'hF0);
        step(1'b1, 2'd1, 32'h100, 32'h001, 1'b1);
        check("pushpop_level", {62'd0, level}, 64'd1);
        check("pushpop_head", {32'd0, rsp_result}, 64'h101);
        step(1'b0, 2'd0, '0, '0, 1'b1);

        // Op 3, configuration dependent
        step(1'b1, 2'd3, 32'h0000_FFFF, 32'h00FF_0000, 1'b1);
        check("op3_result", {32'd0, rsp_result}, {32'd0, exp_op3});
        check("op3_zero", {63'd0, rsp_zero}, {63'd0, exp_op3_zero});
        step(1'b0, 2'd0, '0, '0, 1'b1);

        // Asynchronous reset while full
        step(1'b1, 2'd1, 32'h5, 32'hA, 1'b0);
        step(1'b1, 2'd0, 32'hFF, 32'hF0, 1'b0);
        check("pre_rst_level", {62'd0, level}, 64'd2);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("mid_rst_level", {62'd0, level}, 64'd0);
        check("mid_rst_result", {32'd0, rsp_result}, 64'd0);
        check("mid_rst_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_a     = 32'h77;
        req_b     = 32'h88;
        @(posedge clk);
        #1;
        check("in_rst_no_accept", {62'd0, level}, 64'd0);
        reset = 1'b0;
        step(1'b1, 2'd1, 32'h12, 32'h21, 1'b0);
        check("post_rst_level", {62'd0, level}, 64'd1);
        check("post_rst_head", {32'd0, rsp_result}, 64'h33);
        step(1'b0, 2'd0, '0, '0, 1'b1);
        check("post_rst_drained", {62'd0, level}, 64'd0);

        // Mixed traffic checked by the model every cycle
        for (int i = 0; i < 24; i++) begin
            step((i % 3) != 2, 2'(i % 4), 32'hA5A5_0000 ^ (i * 32'h0101_0101),
                 32'h0F0F_F0F0 + 32'(i), (i % 4) < 2);
        end
        repeat (3) step(1'b0, 2'd0, '0, '0, 1'b1);
        check("final_level", {62'd0, level}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port req_op, input, 2 bits: the operation select.
REQ-007 The block SHALL have ports req_a and req_b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: a result is present.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port rsp_result, output, WIDTH bits: the head result.
REQ-011 The block SHALL have port rsp_zero, output, 1 bit: the head result equals zero.
REQ-012 The block SHALL have port level, output, 2 bits: buffer occupancy, 0 to 2.

Function
REQ-013 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-014 A response SHALL be popped on a rising edge where rsp_valid=1 and rsp_ready=1.
REQ-015 The result SHALL be computed from req_op, req_a and req_b at acceptance and stored in a 2-entry in-order FIFO.
- op 0: A & B.
- op 1: A | B.
- op 2: A ^ B.
- op 3: see REQ-026/027.
REQ-016 The latency SHALL be one cycle: an entry accepted at edge N makes rsp_valid=1 after edge N when the FIFO was empty.
REQ-017 There SHALL be no combinational path from the request inputs to the response outputs.
REQ-018 req_ready SHALL equal (level != 2) and SHALL NOT depend on rsp_ready.
REQ-019 rsp_valid SHALL equal (level != 0).
REQ-020 rsp_result and rsp_zero SHALL reflect the head entry; rsp_zero SHALL be registered with the entry.
REQ-021 A simultaneous push and pop at level 1 SHALL keep level at 1, with the new entry becoming the head.
- A simultaneous push and pop at level 2 cannot occur, because req_ready=0.
REQ-022 Pop attempts while empty and push attempts while full SHALL be ignored, with no state change.
REQ-023 Read and write pointers SHALL wrap modulo 2, and results SHALL leave the FIFO in acceptance order.

Reset
REQ-024 Asserting reset SHALL immediately, independent of clk, clear the following:
- level=0.
- Both pointers=0.
- rsp_valid=0.
- req_ready=1.
- Stored entries=0, so rsp_result=0 and rsp_zero=1.
REQ-025 A reset asserted mid-operation SHALL discard all buffered results, and no request SHALL be accepted while reset=1.

Configuration
REQ-026 With macro LOGIC_NOR_EN defined, op 3 SHALL produce ~(A | B).
REQ-027 Without LOGIC_NOR_EN, op 3 SHALL produce A & B (an AND alias), and the interface SHALL be unchanged.

Verification
REQ-028 Scenario: reset, then push op 0, A=0xF0F0F0F0, B=0xFF00FF00, rsp_ready=1 -> rsp_valid one cycle later, rsp_result=0xF000F000, rsp_zero=0.
REQ-029 Scenario: rsp_ready=0, push op 1 (0x1,0x2) then op 2 (0xFFFFFFFF,0xFFFFFFFF) -> the following hold:
- level=2 and req_ready=0.
- A third request is ignored.
- Releasing rsp_ready yields 0x3, then 0x0 with rsp_zero=1.
REQ-030 Scenario: at level 1, push and pop on the same edge -> level stays 1, and the head becomes the new result.
REQ-031 Scenario: op 3, A=0x0000FFFF, B=0x00FF0000 -> the following hold:
- With LOGIC_NOR_EN: result 0xFF000000.
- Without LOGIC_NOR_EN: result 0x00000000 with rsp_zero=1.
REQ-032 Scenario: assert reset between clock edges with level=2 -> the following hold immediately:
- rsp_valid=0, level=0, rsp_result=0, req_ready=1.
- After release, the first push returns only the new result.
